// File: rtl/led_pkg.sv
// Shared types and constants for the multi-channel LED pattern generator.
package led_pkg;

   typedef enum logic [1:0] {
      LED_OFF   = 2'd0,
      LED_ON    = 2'd1,
      LED_BLINK = 2'd2,
      LED_PWM   = 2'd3
   } led_mode_t;

   localparam int PWM_W = 8;

endpackage

// File: rtl/led_pattern_gen_if.sv
// Per-channel configuration and LED output bundle between the board controller and led_pattern_gen.
interface led_pattern_gen_if
   import led_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int CNT_W = 26
);

   led_mode_t [NCH-1:0]             mode;
   logic      [NCH-1:0][CNT_W-1:0]  half_period;
   logic      [NCH-1:0][PWM_W-1:0]  duty;
   logic                            sync;
   logic      [NCH-1:0]             led;

   modport master (
      output mode,
      output half_period,
      output duty,
      output sync,
      input  led
   );

   modport slave (
      input  mode,
      input  half_period,
      input  duty,
      input  sync,
      output led
   );

endinterface

// File: rtl/led_pattern_gen_channel.sv
// One LED channel: blink half-period counter, PWM phase, mode history and the registered LED bit.
module led_channel
   import led_pkg::*;
#(
   parameter int CNT_W = 26
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic               tick,
   input  logic               restart,
   input  led_mode_t          mode,
   input  logic [CNT_W-1:0]   half_period,
   input  logic [PWM_W-1:0]   duty,
   output logic               led
);

   logic [CNT_W-1:0] cnt, cnt_next;
   logic             bstate, bstate_next;
   logic [PWM_W-1:0] phase, phase_next;
   led_mode_t        mode_q;
   logic             led_next;
   logic             restart_any;
   logic [CNT_W-1:0] hp;

   // A mode change restarts the channel just like the global sync does.
   assign restart_any = restart || (mode != mode_q);
   assign hp          = (half_period == '0) ? CNT_W'(1) : half_period;

   always_comb begin
      cnt_next    = cnt;
      bstate_next = bstate;
      phase_next  = phase;
      if (restart_any) begin
         cnt_next    = CNT_W'(1);
         bstate_next = 1'b0;
         phase_next  = '0;
      end else if (tick) begin
         phase_next = phase + PWM_W'(1);
         // >= lets a lowered half_period take effect on the very next tick.
         if (cnt >= hp) begin
            cnt_next    = CNT_W'(1);
            bstate_next = ~bstate;
         end else begin
            cnt_next = cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      led_next = 1'b0;
      case (mode)
         LED_OFF:   led_next = 1'b0;
         LED_ON:    led_next = 1'b1;
         LED_BLINK: led_next = bstate_next;
         LED_PWM:   led_next = (phase_next < duty);
         default:   led_next = 1'b0;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         cnt    <= CNT_W'(1);
         bstate <= 1'b0;
         phase  <= '0;
         mode_q <= LED_OFF;
         led    <= 1'b0;
      end else begin
         cnt    <= cnt_next;
         bstate <= bstate_next;
         phase  <= phase_next;
         mode_q <= mode;
         led    <= led_next;
      end
   end

endmodule

// File: rtl/led_pattern_gen.sv
// Top of the LED pattern generator: shared tick prescaler plus NCH independent channels.
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int NCH      = 4,
   parameter int CNT_W    = 26,
   parameter int PRESCALE = 1
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   led_pattern_gen_if.slave  bus
);

   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PRE_W-1:0] pre_cnt;
   logic             tick;
   logic [NCH-1:0]   led_vec;

   assign tick = (pre_cnt == PRE_W'(PRESCALE - 1));

   // Sync realigns the tick grid so every channel restarts from the same phase.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         pre_cnt <= '0;
      end else if (bus.sync || tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PRE_W'(1);
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_channel
      led_channel #(
         .CNT_W (CNT_W)
      ) u_channel (
         .sys_clk     (sys_clk),
         .sys_rst_n   (sys_rst_n),
         .tick        (tick),
         .restart     (bus.sync),
         .mode        (bus.mode[i]),
         .half_period (bus.half_period[i]),
         .duty        (bus.duty[i]),
         .led         (led_vec[i])
      );
   end

   assign bus.led = led_vec;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed self-checking bench for led_pattern_gen: one instance ticking every cycle, one with PRESCALE=5.
module tb_led_pattern_gen;
   import led_pkg::*;

   localparam int NCH   = 4;
   localparam int CNT_W = 26;

   logic sys_clk;
   logic sys_rst_n;
   int   check_count;
   int   pass_count;
   int   high_count;

   led_pattern_gen_if #(.NCH(NCH), .CNT_W(CNT_W)) bus_a ();
   led_pattern_gen_if #(.NCH(NCH), .CNT_W(CNT_W)) bus_b ();

   led_pattern_gen #(.NCH(NCH), .CNT_W(CNT_W), .PRESCALE(1)) dut_a (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus_a.slave)
   );

   led_pattern_gen #(.NCH(NCH), .CNT_W(CNT_W), .PRESCALE(5)) dut_b (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus_b.slave)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic stepCycle();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic applyStimulus(input int ch, input led_mode_t m,
                                input logic [CNT_W-1:0] hp, input logic [7:0] d);
      bus_a.mode[ch]        = m;
      bus_a.half_period[ch] = hp;
      bus_a.duty[ch]        = d;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      if (observed === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   initial begin
      check_count = 0;
      pass_count  = 0;
      sys_rst_n   = 1'b0;
      bus_a.sync  = 1'b0;
      bus_b.sync  = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         applyStimulus(i, LED_ON, CNT_W'(3), 8'd0);
         bus_b.mode[i]        = LED_OFF;
         bus_b.half_period[i] = CNT_W'(2);
         bus_b.duty[i]        = 8'd0;
      end
      bus_b.mode[2] = LED_BLINK;

      for (int i = 0; i < 3; i++) begin
         stepCycle();
         checkOutput("reset_hold", 32'(bus_a.led), 32'h0);
      end
      sys_rst_n = 1'b1;
      stepCycle();
      checkOutput("reset_release_on", 32'(bus_a.led), 32'hF);

      // Blink hp=3: restart edge, then toggles every 3 edges.
      applyStimulus(0, LED_BLINK, CNT_W'(3), 8'd0);
      stepCycle();
      checkOutput("blink_restart", 32'(bus_a.led[0]), 32'h0);
      for (int k = 1; k <= 12; k++) begin
         stepCycle();
         checkOutput("blink_hp3", 32'(bus_a.led[0]), 32'((k / 3) % 2));
      end

      bus_a.half_period[0] = '0;
      for (int k = 1; k <= 4; k++) begin
         stepCycle();
         checkOutput("blink_hp0", 32'(bus_a.led[0]), 32'(k % 2));
      end

      // Period shrink from 10 to 4 with cnt at 7.
      bus_a.half_period[0] = CNT_W'(10);
      bus_a.sync = 1'b1;
      stepCycle();
      bus_a.sync = 1'b0;
      checkOutput("shrink_restart", 32'(bus_a.led[0]), 32'h0);
      for (int k = 1; k <= 6; k++) stepCycle();
      checkOutput("shrink_before", 32'(bus_a.led[0]), 32'h0);
      bus_a.half_period[0] = CNT_W'(4);
      stepCycle();
      checkOutput("shrink_toggle", 32'(bus_a.led[0]), 32'h1);
      for (int k = 1; k <= 3; k++) stepCycle();
      checkOutput("shrink_hold", 32'(bus_a.led[0]), 32'h1);
      stepCycle();
      checkOutput("shrink_period4", 32'(bus_a.led[0]), 32'h0);

      // PWM duty 64 over one full 256-cycle period.
      applyStimulus(1, LED_PWM, CNT_W'(3), 8'd64);
      stepCycle();
      checkOutput("pwm_start_high", 32'(bus_a.led[1]), 32'h1);
      high_count = 1;
      for (int i = 1; i <= 255; i++) begin
         stepCycle();
         if (bus_a.led[1]) high_count++;
         if (i == 63) checkOutput("pwm_phase63", 32'(bus_a.led[1]), 32'h1);
         if (i == 64) checkOutput("pwm_phase64", 32'(bus_a.led[1]), 32'h0);
      end
      checkOutput("pwm_duty64_count", 32'(high_count), 32'd64);

      bus_a.duty[1] = 8'd0;
      high_count = 0;
      for (int i = 0; i < 256; i++) begin
         stepCycle();
         if (bus_a.led[1]) high_count++;
      end
      checkOutput("pwm_duty0_count", 32'(high_count), 32'd0);

      // Prescaler 5 with hp=2: toggles every 10 cycles, sync restarts mid-count.
      bus_b.sync = 1'b1;
      stepCycle();
      bus_b.sync = 1'b0;
      checkOutput("presc_restart", 32'(bus_b.led), 32'h0);
      for (int k = 1; k <= 15; k++) begin
         stepCycle();
         if (k == 9)  checkOutput("presc_k9", 32'(bus_b.led[2]), 32'h0);
         if (k == 10) checkOutput("presc_k10", 32'(bus_b.led), 32'h4);
         if (k == 15) checkOutput("presc_k15", 32'(bus_b.led[2]), 32'h1);
      end
      bus_b.sync = 1'b1;
      stepCycle();
      bus_b.sync = 1'b0;
      checkOutput("presc_sync_mid", 32'(bus_b.led[2]), 32'h0);
      for (int k = 1; k <= 10; k++) begin
         stepCycle();
         if (k == 9)  checkOutput("presc_resync_k9", 32'(bus_b.led[2]), 32'h0);
         if (k == 10) checkOutput("presc_resync_k10", 32'(bus_b.led[2]), 32'h1);
      end

      // Mode change coinciding with sync gives one restart.
      bus_a.mode[3]        = LED_BLINK;
      bus_a.half_period[3] = CNT_W'(3);
      bus_a.sync           = 1'b1;
      stepCycle();
      bus_a.sync = 1'b0;
      checkOutput("modesync_restart", 32'(bus_a.led[3]), 32'h0);
      stepCycle();
      stepCycle();
      checkOutput("modesync_k2", 32'(bus_a.led[3]), 32'h0);
      stepCycle();
      checkOutput("modesync_k3", 32'(bus_a.led[3]), 32'h1);

      // Reset in the middle of a PWM pattern.
      applyStimulus(1, LED_PWM, CNT_W'(3), 8'd64);
      for (int i = 0; i < 100; i++) stepCycle();
      sys_rst_n = 1'b0;
      stepCycle();
      checkOutput("midreset_led", 32'(bus_a.led), 32'h0);
      sys_rst_n = 1'b1;
      stepCycle();
      checkOutput("midreset_release", 32'(bus_a.led), 32'h6);
      for (int i = 1; i <= 63; i++) stepCycle();
      checkOutput("midreset_phase63", 32'(bus_a.led[1]), 32'h1);
      stepCycle();
      checkOutput("midreset_phase64", 32'(bus_a.led[1]), 32'h0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
